// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: shared state encoding and depth helper for the program memory
package prog_mem_pkg;
  typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;
  function automatic int unsigned mem_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction
endpackage

// File: rtl/prog_mem_array.sv
// prog_mem_array: single write port storage with a registered read port
module prog_mem_array
  import prog_mem_pkg::*;
#(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0] rdata
);
  logic [DATA_SIZE-1:0] mem [mem_depth(ADDR_SIZE)];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // storage itself is never reset; only the read register is, so fetch_data starts at 0
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/prog_mem_ld.sv
// prog_mem_ld: program memory with power-on clear sweep, streamed loader and registered fetch port
module prog_mem_ld
  import prog_mem_pkg::*;
#(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 fetch_req,
  input  logic [ADDR_SIZE-1:0] fetch_addr,
  output logic                 fetch_ready,
  output logic                 fetch_valid,
  output logic [DATA_SIZE-1:0] fetch_data,
  input  logic                 ld_start,
  input  logic [ADDR_SIZE-1:0] ld_base,
  input  logic                 ld_valid,
  input  logic [DATA_SIZE-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 ld_ready,
  output logic                 ld_done,
  output logic [ADDR_SIZE:0]   ld_count,
  output logic                 mem_ready
);
  localparam logic [ADDR_SIZE:0] CNT_MAX = (ADDR_SIZE+1)'(mem_depth(ADDR_SIZE));
  state_t state;
  logic [ADDR_SIZE-1:0] clr_ptr, wr_ptr, waddr;
  logic [DATA_SIZE-1:0] wdata;
  logic ld_fire, fetch_fire, we;
  assign ld_fire = ld_ready & ld_valid;
  assign fetch_fire = fetch_ready & fetch_req;
  assign mem_ready = fetch_ready;
  always_comb begin
    we = (state == CLEAR) | ld_fire;
    waddr = (state == CLEAR) ? clr_ptr : wr_ptr;
    wdata = (state == CLEAR) ? '0 : ld_data;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= CLEAR;
      clr_ptr <= '0;
      wr_ptr <= '0;
      fetch_ready <= 1'b0;
      fetch_valid <= 1'b0;
      ld_ready <= 1'b0;
      ld_done <= 1'b0;
      ld_count <= '0;
    end else begin
      fetch_valid <= fetch_fire;
      ld_done <= 1'b0;
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) begin
            state <= IDLE;
            fetch_ready <= 1'b1;
          end
        end
        IDLE: if (ld_start) begin
          wr_ptr <= ld_base;
          ld_count <= '0;
          state <= LOAD;
          fetch_ready <= 1'b0;
          ld_ready <= 1'b1;
        end
        LOAD: if (ld_fire) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (ld_count != CNT_MAX) ld_count <= ld_count + 1'b1;
          if (ld_last) begin
            state <= IDLE;
            ld_done <= 1'b1;
            ld_ready <= 1'b0;
            fetch_ready <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  prog_mem_array #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_array (
    .clk(clk),
    .rstn(rstn),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .re(fetch_fire),
    .raddr(fetch_addr),
    .rdata(fetch_data)
  );
endmodule

// File: tb/tb_prog_mem_ld.sv
// tb_prog_mem_ld: directed stimulus with a fetch scoreboard drained by an independent monitor
module tb_prog_mem_ld;
  logic clk = 0, rstn = 0, fetch_req = 0, ld_start = 0, ld_valid = 0, ld_last = 0;
  logic [4:0] fetch_addr = '0, ld_base = '0;
  logic [5:0] ld_data = '0;
  logic fetch_ready, fetch_valid, ld_ready, ld_done, mem_ready;
  logic [5:0] fetch_data, ld_count;
  typedef struct {logic [5:0] d; int c;} exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, n_chk = 0, n_fail = 0, m_chk = 0, m_fail = 0, done_cnt = 0, d0;
  bit saw;
  prog_mem_ld dut (
    .clk(clk), .rstn(rstn),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .ld_done(ld_done), .ld_count(ld_count),
    .mem_ready(mem_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ld_done) begin
      done_cnt++;
      m_chk++;
      if (!fetch_ready) begin
        m_fail++;
        $display("FAIL done_with_ready: fetch_ready %0b expected 1", fetch_ready);
      end
    end
    if (fetch_valid) begin
      m_chk++;
      if (q.size() == 0) begin
        m_fail++;
        $display("FAIL unexpected_fetch_valid: data %0h at cycle %0d, nothing expected", fetch_data, cyc);
      end else begin
        e = q.pop_front();
        if (fetch_data !== e.d || cyc != e.c) begin
          m_fail++;
          $display("FAIL fetch: got %0h at cycle %0d expected %0h at cycle %0d", fetch_data, cyc, e.d, e.c);
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [4:0] a, input logic [5:0] d);
    fetch_req = 1;
    fetch_addr = a;
    q.push_back('{d, cyc + 1});
    tick();
    fetch_req = 0;
  endtask
  task automatic wait_ready(input int exp_cyc);
    int k = 0;
    saw = 0;
    while (!mem_ready && k < 100) begin
      tick();
      k++;
      saw |= ld_ready;
    end
    chk("clear_length", k, exp_cyc);
    chk("fetch_ready_after_clear", fetch_ready, 1);
  endtask
  task automatic load_start(input logic [4:0] b);
    ld_start = 1;
    ld_base = b;
    tick();
    ld_start = 0;
  endtask
  task automatic load_words(input logic [23:0] w, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        ld_valid = 0;
        ld_last = 1;
        ld_data = 6'h3f;
        tick();
      end
      ld_valid = 1;
      ld_data = w[6*i +: 6];
      ld_last = (i == n - 1);
      tick();
    end
    ld_valid = 0;
    ld_last = 0;
  endtask
  initial begin
    #3 chk("reset_outputs", {fetch_ready, fetch_valid, fetch_data, ld_ready, ld_done, ld_count, mem_ready}, 0);
    ld_start = 1;
    fetch_req = 1;
    fetch_addr = 5'd3;
    @(posedge clk);
    #1 rstn = 1;
    wait_ready(32);
    chk("ld_ready_in_clear", saw, 0);
    ld_start = 0;
    fetch_req = 0;
    for (int a = 0; a < 32; a++) fetch(5'(a), 6'd0);
    d0 = done_cnt;
    load_start(5'd5);
    chk("ld_ready_in_load", ld_ready, 1);
    chk("fetch_ready_in_load", fetch_ready, 0);
    fetch_req = 1;
    fetch_addr = 5'd5;
    load_words({6'd4, 6'd3, 6'd2, 6'd1}, 4, 1);
    fetch_req = 0;
    chk("ld_count_4", ld_count, 4);
    tick();
    chk("ld_done_once", done_cnt - d0, 1);
    chk("ld_done_low", ld_done, 0);
    fetch(5'd4, 6'd0);
    for (int a = 5; a < 9; a++) fetch(5'(a), 6'(a - 4));
    fetch(5'd9, 6'd0);
    load_start(5'd30);
    load_words({6'h15, 6'h2a, 6'h3f}, 3, 0);
    chk("ld_count_wrap", ld_count, 3);
    fetch(5'd29, 6'd0);
    fetch(5'd30, 6'h3f);
    fetch(5'd31, 6'h2a);
    fetch(5'd0, 6'h15);
    fetch(5'd1, 6'd0);
    load_start(5'd5);
    load_words(24'd7, 1, 0);
    fetch_req = 1;
    fetch_addr = 5'd5;
    q.push_back('{6'd7, cyc + 1});
    load_start(5'd5);
    fetch_req = 0;
    load_words(24'd9, 1, 0);
    chk("ld_count_1", ld_count, 1);
    fetch(5'd5, 6'd9);
    fetch(5'd6, 6'd2);
    tick();
    load_start(5'd0);
    ld_valid = 1;
    ld_data = 6'h11;
    tick();
    ld_data = 6'h22;
    tick();
    ld_valid = 0;
    chk("ld_count_partial", ld_count, 2);
    rstn = 0;
    #1 chk("reset_async", {fetch_ready, fetch_valid, fetch_data, ld_ready, ld_done, ld_count, mem_ready}, 0);
    tick();
    rstn = 1;
    wait_ready(32);
    for (int a = 0; a < 32; a++) fetch(5'(a), 6'd0);
    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk + m_chk, n_fail + m_fail);
    $finish;
  end
endmodule

// File: doc/prog_mem_ld.md
# prog_mem_ld

Parametrised program memory with built-in loader and registered fetch port. After reset it sweeps every word to zero, then serves instruction fetches with one-cycle latency. It also accepts a word-serial program image over a valid/ready stream, written from a programmable base address. It sits between the boot/debug loader and the core's fetch stage, replacing the reset-cleared, load-less program store.

## Interface
- DATA_SIZE, 6, instruction word width
- ADDR_SIZE, 5, address width; depth = 2**ADDR_SIZE
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- fetch_req  in  1  fetch request, sampled when fetch_ready=1
- fetch_addr  in  ADDR_SIZE  fetch address
- fetch_ready  out  1  fetch port available (state IDLE)
- fetch_valid  out  1  fetch_data valid, one cycle after accepted request
- fetch_data  out  DATA_SIZE  fetched word, held until next accepted fetch
- ld_start  in  1  begin load; sampled in IDLE only
- ld_base  in  ADDR_SIZE  first load address, captured with ld_start
- ld_valid  in  1  load word valid
- ld_data  in  DATA_SIZE  load word
- ld_last  in  1  marks final word, qualified by ld_valid&ld_ready
- ld_ready  out  1  load word accepted when ld_valid=1 (state LOAD)
- ld_done  out  1  one-cycle pulse after final word written
- ld_count  out  ADDR_SIZE+1  words written in current/last load, saturating
- mem_ready  out  1  init sweep complete and not loading

## Operation
- States: CLEAR, IDLE, LOAD.
- CLEAR (entered on reset):
  - Writes 0 to address clr_ptr each cycle; clr_ptr runs 0 to 2**ADDR_SIZE-1.
  - After the last address, moves to IDLE.
  - ld_start and fetch_req are ignored.
- IDLE:
  - fetch_req=1 reads fetch_addr.
  - ld_start=1 captures ld_base into wr_ptr, clears ld_count, moves to LOAD.
  - fetch_req and ld_start in the same cycle: the fetch is accepted and returns pre-load contents; LOAD begins next cycle.
- LOAD:
  - ld_ready=1.
  - Each ld_valid word writes mem[wr_ptr]; wr_ptr increments modulo 2**ADDR_SIZE (wraps to 0 past top).
  - ld_count increments and saturates at 2**ADDR_SIZE.
  - A word with ld_last writes, then the block returns to IDLE and pulses ld_done.
  - ld_start is ignored in LOAD.
  - fetch_ready=0; fetch_req is ignored.
- fetch_data is a registered read of the array and updates only on an accepted fetch.
- Writing more than 2**ADDR_SIZE words overwrites from wr_ptr wrap; no error flag.
- Reset mid-load or mid-clear: async return to CLEAR, sweep restarts from address 0, partial image discarded.

## Timing
- Reset values:
  - fetch_ready=0, fetch_valid=0, fetch_data=0
  - ld_ready=0, ld_done=0, ld_count=0
  - mem_ready=0
  - state=CLEAR, clr_ptr=0
- CLEAR length: 2**ADDR_SIZE cycles after the first clk edge with rstn=1; mem_ready and fetch_ready rise on the following cycle.
- Fetch latency: request accepted at edge N; fetch_valid=1 and fetch_data valid after edge N+1. fetch_valid is a single-cycle pulse per request. Back-to-back requests give one word per cycle.
- Load: one word per cycle at most; write visible to a fetch accepted from the cycle after returning to IDLE.
- ld_done asserts the cycle after the ld_last handshake, concurrent with fetch_ready=1.
- mem_ready = fetch_ready.

## Structure
- Package prog_mem_pkg: state enum typedef (CLEAR, IDLE, LOAD) and a depth-function constant helper.
- Sub-module prog_mem_array: single write port, single registered read port, no reset on storage. The FSM, pointers and handshakes live in prog_mem_ld.

## Test plan
- Reset release, defaults: mem_ready=0 for exactly 32 cycles, then 1; fetch of every address 0..31 returns 0 with fetch_valid one cycle after each request.
- Load base=5, words 1..4, ld_last on 4th: ld_done pulse once, ld_count=4; fetch 5..8 returns 1..4, fetch 9 returns 0.
- Wrap: base=30, three words 0x3F,0x2A,0x15 with ld_last on third: addresses 30,31,0 hold them; ld_count=3.
- ld_start and fetch_req(addr 5) in the same IDLE cycle after a prior load of 7 at addr 5: fetch returns 7; new load writes 9 to addr 5; a later fetch returns 9.
- Stall and ignore: ld_valid toggling with gaps during LOAD gives no extra writes. fetch_req during LOAD gets no fetch_valid. ld_start during CLEAR gets no ld_ready.
- rstn asserted after 2 of 4 load words: outputs return to reset values asynchronously; after the sweep, all addresses read 0.
